// File: rtl/isa_unit.sv
// isa_unit: single-cycle register-register execution unit.
//
// Each rising clk edge executes the 20-bit instruction on `instruccion`.
// Operands are read combinationally from a 32 x 32-bit register file. The
// result is registered onto `salida` and, if enabled, written back to rd.
//
// Ports
//   clk          in   1   clock; all state updates on the rising edge
//   rst          in   1   synchronous active-high reset
//   instruccion  in  20   {opcode[19:16], rd[15:11], rs1[10:6], rs2[5:1], we[0]}
//   salida       out 32   registered result of the last executed instruction
//
// Reset loads salida=0 and reg[i]=i. Register 0 always reads as zero and
// ignores writes.
module isa_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] instruccion,
  output logic [31:0] salida
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLT  = 4'b0101,
    OP_SLL  = 4'b0110,
    OP_SRL  = 4'b0111,
    OP_NOR  = 4'b1000,
    OP_MOV  = 4'b1001,
    OP_SLTU = 4'b1010
  } op_e;

  // Instruction fields
  logic [3:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        we;

  assign opcode = instruccion[19:16];
  assign rd     = instruccion[15:11];
  assign rs1    = instruccion[10:6];
  assign rs2    = instruccion[5:1];
  assign we     = instruccion[0];

  // State
  logic [31:0] rf_q [32];
  logic [31:0] salida_q;

  // Datapath
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result_d;
  logic        op_valid;
  logic        wr_en;

  // Reads come straight from the array, so a register written on this edge
  // still returns its old value to the current instruction; the next
  // instruction sees the new value without any bypass.
  always_comb begin
    op_a = (rs1 == '0) ? '0 : rf_q[rs1];
    op_b = (rs2 == '0) ? '0 : rf_q[rs2];
  end

  always_comb begin
    result_d = '0;
    op_valid = 1'b1;
    case (op_e'(opcode))
      OP_ADD:  result_d = op_a + op_b;
      OP_SUB:  result_d = op_a - op_b;
      OP_AND:  result_d = op_a & op_b;
      OP_OR:   result_d = op_a | op_b;
      OP_XOR:  result_d = op_a ^ op_b;
      OP_SLT:  result_d = ($signed(op_a) < $signed(op_b)) ? 32'd1 : '0;
      OP_SLL:  result_d = op_a << op_b[4:0];
      OP_SRL:  result_d = op_a >> op_b[4:0];
      OP_NOR:  result_d = ~(op_a | op_b);
      OP_MOV:  result_d = op_a;
      OP_SLTU: result_d = (op_a < op_b) ? 32'd1 : '0;
      default: begin
        result_d = '0;
        op_valid = 1'b0;
      end
    endcase
  end

  assign wr_en = we && op_valid && (rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      salida_q <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= i;
      end
    end else begin
      salida_q <= result_d;
      if (wr_en) begin
        rf_q[rd] <= result_d;
      end
    end
  end

  assign salida = salida_q;

endmodule

// File: tb/tb_isa_unit.sv
// Directed testbench for isa_unit. Instructions are driven on the falling
// edge and salida is sampled 1 ns after the rising edge. Register contents
// are observed by issuing MOV instructions with we=0.
module tb_isa_unit;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1000;
  localparam logic [3:0] OP_MOV  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

  logic        clk;
  logic        rst;
  logic [19:0] instruccion;
  logic [31:0] salida;

  int tests_run;
  int tests_failed;

  isa_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruccion (instruccion),
    .salida      (salida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [19:0] enc(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic we);
    return {op, rd, rs1, rs2, we};
  endfunction

  // Present one instruction with rst low and wait until salida reflects it.
  task automatic exec(input logic [19:0] ins);
    @(negedge clk);
    rst         = 1'b0;
    instruccion = ins;
    @(posedge clk);
    #1;
  endtask

  // One reset edge with the given instruction on the bus.
  task automatic reset_cycle(input logic [19:0] ins);
    @(negedge clk);
    rst         = 1'b1;
    instruccion = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [19:0] ins [4];
    logic [31:0] exp [4];
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    exec(enc(OP_ADD, 5'd0, 5'd1, 5'd1, 1'b0));
    tests_run++;
    if (salida !== 32'd2) begin
      tests_failed++;
      $display("FAIL reset_pre: salida=%h expected %h", salida, 32'd2);
    end
    reset_cycle(enc(OP_ADD, 5'd0, 5'd1, 5'd1, 1'b0));
    tests_run++;
    if (salida !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_salida: salida=%h expected %h", salida, 32'd0);
    end
    ins = '{enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0), enc(OP_MOV, 5'd0, 5'd1, 5'd0, 1'b0),
            enc(OP_MOV, 5'd0, 5'd17, 5'd0, 1'b0), enc(OP_MOV, 5'd0, 5'd31, 5'd0, 1'b0)};
    exp = '{32'd0, 32'd1, 32'd17, 32'd31};
    for (int i = 0; i < 4; i++) begin
      exec(ins[i]);
      tests_run++;
      if (salida !== exp[i]) begin
        tests_failed++;
        $display("FAIL reset_regs[%0d]: salida=%h expected %h", i, salida, exp[i]);
      end
    end
  endtask

  task automatic test_add();
    logic [19:0] ins [4];
    logic [31:0] exp [4];
    ins = '{20'h02887, enc(OP_MOV, 5'd0, 5'd5, 5'd0, 1'b0),
            enc(OP_ADD, 5'd5, 5'd5, 5'd5, 1'b1), enc(OP_MOV, 5'd0, 5'd5, 5'd0, 1'b0)};
    exp = '{32'd5, 32'd5, 32'd10, 32'd10};
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      exec(ins[i]);
      tests_run++;
      if (salida !== exp[i]) begin
        tests_failed++;
        $display("FAIL add[%0d]: salida=%h expected %h", i, salida, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] ins [3];
    logic [31:0] exp [3];
    ins = '{20'h11C87, enc(OP_MOV, 5'd4, 5'd3, 5'd0, 1'b1),
            enc(OP_MOV, 5'd0, 5'd4, 5'd0, 1'b0)};
    exp = '{32'd15, 32'd15, 32'd15};
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      exec(ins[i]);
      tests_run++;
      if (salida !== exp[i]) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: salida=%h expected %h", i, salida, exp[i]);
      end
    end
  endtask

  task automatic test_signed_compare();
    logic [19:0] ins [8];
    logic [31:0] exp [8];
    ins = '{20'h13045,
            enc(OP_SLT,  5'd7, 5'd6, 5'd1, 1'b1),
            enc(OP_SLTU, 5'd8, 5'd6, 5'd1, 1'b1),
            enc(OP_SLT,  5'd0, 5'd1, 5'd6, 1'b0),
            enc(OP_SLTU, 5'd0, 5'd1, 5'd6, 1'b0),
            enc(OP_MOV,  5'd0, 5'd7, 5'd0, 1'b0),
            enc(OP_MOV,  5'd0, 5'd8, 5'd0, 1'b0),
            enc(OP_SLT,  5'd0, 5'd5, 5'd5, 1'b0)};
    exp = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1, 32'd1, 32'd0, 32'd0};
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      exec(ins[i]);
      tests_run++;
      if (salida !== exp[i]) begin
        tests_failed++;
        $display("FAIL signed_compare[%0d]: salida=%h expected %h", i, salida, exp[i]);
      end
    end
  endtask

  task automatic test_reg0();
    logic [19:0] ins [3];
    logic [31:0] exp [3];
    ins = '{enc(OP_ADD, 5'd0, 5'd4, 5'd4, 1'b1),
            enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0),
            enc(OP_ADD, 5'd3, 5'd0, 5'd7, 1'b0)};
    exp = '{32'd8, 32'd0, 32'd7};
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      exec(ins[i]);
      tests_run++;
      if (salida !== exp[i]) begin
        tests_failed++;
        $display("FAIL reg0[%0d]: salida=%h expected %h", i, salida, exp[i]);
      end
    end
  endtask

  task automatic test_no_write();
    logic [19:0] ins [8];
    logic [31:0] exp [8];
    ins = '{enc(OP_ADD, 5'd9, 5'd1, 5'd1, 1'b0),
            enc(OP_MOV, 5'd0, 5'd9, 5'd0, 1'b0),
            enc(4'b1011, 5'd10, 5'd20, 5'd3, 1'b1),
            enc(4'b1100, 5'd10, 5'd20, 5'd3, 1'b1),
            enc(4'b1101, 5'd10, 5'd20, 5'd3, 1'b1),
            enc(4'b1110, 5'd10, 5'd20, 5'd3, 1'b1),
            enc(4'b1111, 5'd10, 5'd20, 5'd3, 1'b1),
            enc(OP_MOV, 5'd0, 5'd10, 5'd0, 1'b0)};
    exp = '{32'd2, 32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd10};
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      exec(ins[i]);
      tests_run++;
      if (salida !== exp[i]) begin
        tests_failed++;
        $display("FAIL no_write[%0d]: salida=%h expected %h", i, salida, exp[i]);
      end
    end
  endtask

  task automatic test_logic_ops();
    logic [19:0] ins [8];
    logic [31:0] exp [8];
    ins = '{enc(OP_AND, 5'd0, 5'd12, 5'd10, 1'b0),
            enc(OP_OR,  5'd0, 5'd12, 5'd10, 1'b0),
            enc(OP_XOR, 5'd0, 5'd12, 5'd10, 1'b0),
            enc(OP_NOR, 5'd0, 5'd12, 5'd10, 1'b0),
            enc(OP_SUB, 5'd0, 5'd10, 5'd12, 1'b0),
            enc(OP_NOR, 5'd20, 5'd0, 5'd0, 1'b1),
            enc(OP_ADD, 5'd0, 5'd20, 5'd2, 1'b0),
            enc(OP_SUB, 5'd0, 5'd0, 5'd20, 1'b0)};
    exp = '{32'd8, 32'd14, 32'd6, 32'hFFFF_FFF1, 32'hFFFF_FFFE,
            32'hFFFF_FFFF, 32'd1, 32'd1};
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      exec(ins[i]);
      tests_run++;
      if (salida !== exp[i]) begin
        tests_failed++;
        $display("FAIL logic_ops[%0d]: salida=%h expected %h", i, salida, exp[i]);
      end
    end
  endtask

  task automatic test_shifts();
    logic [19:0] ins [8];
    logic [31:0] exp [8];
    ins = '{enc(OP_SLL, 5'd0, 5'd3, 5'd0, 1'b0),
            enc(OP_SRL, 5'd0, 5'd3, 5'd0, 1'b0),
            enc(OP_SLL, 5'd21, 5'd1, 5'd31, 1'b1),
            enc(OP_SRL, 5'd0, 5'd21, 5'd31, 1'b0),
            enc(OP_SRL, 5'd0, 5'd21, 5'd4, 1'b0),
            enc(OP_SLL, 5'd0, 5'd3, 5'd21, 1'b0),
            enc(OP_SLL, 5'd0, 5'd3, 5'd30, 1'b0),
            enc(OP_SRL, 5'd0, 5'd30, 5'd2, 1'b0)};
    exp = '{32'd3, 32'd3, 32'h8000_0000, 32'd1, 32'h0800_0000,
            32'd3, 32'hC000_0000, 32'd7};
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      exec(ins[i]);
      tests_run++;
      if (salida !== exp[i]) begin
        tests_failed++;
        $display("FAIL shifts[%0d]: salida=%h expected %h", i, salida, exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [19:0] pre [4];
    logic [31:0] pre_exp [4];
    logic [19:0] post [4];
    logic [31:0] post_exp [4];
    pre = '{enc(OP_ADD, 5'd1, 5'd31, 5'd31, 1'b1),
            enc(OP_SUB, 5'd31, 5'd5, 5'd5, 1'b1),
            enc(OP_MOV, 5'd0, 5'd31, 5'd0, 1'b0),
            enc(OP_MOV, 5'd0, 5'd1, 5'd0, 1'b0)};
    pre_exp = '{32'd62, 32'd0, 32'd0, 32'd62};
    post = '{enc(OP_MOV, 5'd0, 5'd31, 5'd0, 1'b0),
             enc(OP_MOV, 5'd0, 5'd1, 5'd0, 1'b0),
             enc(OP_MOV, 5'd0, 5'd2, 5'd0, 1'b0),
             enc(OP_ADD, 5'd0, 5'd31, 5'd1, 1'b0)};
    post_exp = '{32'd31, 32'd1, 32'd2, 32'd32};
    reset_cycle(enc(OP_MOV, 5'd0, 5'd0, 5'd0, 1'b0));
    for (int i = 0; i < 4; i++) begin
      exec(pre[i]);
      tests_run++;
      if (salida !== pre_exp[i]) begin
        tests_failed++;
        $display("FAIL mid_reset_pre[%0d]: salida=%h expected %h", i, salida, pre_exp[i]);
      end
    end
    reset_cycle(enc(OP_ADD, 5'd2, 5'd1, 5'd1, 1'b1));
    tests_run++;
    if (salida !== 32'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_salida: salida=%h expected %h", salida, 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      exec(post[i]);
      tests_run++;
      if (salida !== post_exp[i]) begin
        tests_failed++;
        $display("FAIL mid_reset_post[%0d]: salida=%h expected %h", i, salida, post_exp[i]);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    instruccion  = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_signed_compare();
    test_reg0();
    test_no_write();
    test_logic_ops();
    test_shifts();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
